// File: rtl/note_sequencer.sv
// note_sequencer: playback FSM for one stored track.
// Walks the note-store entries {track, index}. Each note is timed from its length
// field and the tempo, and is followed by a fixed articulation gap.
module note_sequencer #(
   parameter int unsigned TICK_DIV = 3125000
) (
   input  logic       iCLK,
   input  logic       iRST_N,
   input  logic       iSTART,
   input  logic       iSTOP,
   input  logic       iLOOP,
   input  logic [2:0] iTRACK,
   input  logic [3:0] iLAST,
   input  logic [1:0] iTEMPO,
   output logic [6:0] oRD_ADDR,
   input  logic [8:0] iRD_DATA,
   output logic [5:0] oNOTE,
   output logic       oNOTE_VALID,
   output logic [3:0] oNOTE_IDX,
   output logic       oBUSY,
   output logic       oDONE,
   output logic [2:0] oSTATE
);

   localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LOAD  = 3'd2,
      S_PLAY  = 3'd3,
      S_GAP   = 3'd4,
      S_END   = 3'd5
   } state_t;

   state_t        state, state_nxt;
   logic [2:0]    track, track_nxt;
   logic [3:0]    last, last_nxt;
   logic [3:0]    idx, idx_nxt;
   logic [2:0]    len, len_nxt;
   logic [1:0]    tempo, tempo_nxt;
   logic [TW-1:0] tick, tick_nxt;
   logic [1:0]    unit, unit_nxt;
   logic [2:0]    dur, dur_nxt;
   logic [6:0]    addr, addr_nxt;
   logic [5:0]    note, note_nxt;
   logic          valid, valid_nxt;
   logic          busy_nxt, done_nxt;
   logic          busy, done;

   // State and every output register; reset forces all to zero immediately.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state <= S_IDLE;
         track <= '0;
         last  <= '0;
         idx   <= '0;
         len   <= '0;
         tempo <= '0;
         tick  <= '0;
         unit  <= '0;
         dur   <= '0;
         addr  <= '0;
         note  <= '0;
         valid <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         track <= track_nxt;
         last  <= last_nxt;
         idx   <= idx_nxt;
         len   <= len_nxt;
         tempo <= tempo_nxt;
         tick  <= tick_nxt;
         unit  <= unit_nxt;
         dur   <= dur_nxt;
         addr  <= addr_nxt;
         note  <= note_nxt;
         valid <= valid_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
      end
   end

   // Next-state and next-register values. Outputs are registered, so the read
   // address is loaded on the transition into FETCH and the flags follow the
   // next state rather than the current one.
   always_comb begin
      state_nxt = state;
      track_nxt = track;
      last_nxt  = last;
      idx_nxt   = idx;
      len_nxt   = len;
      tempo_nxt = tempo;
      tick_nxt  = tick;
      unit_nxt  = unit;
      dur_nxt   = dur;
      addr_nxt  = addr;
      note_nxt  = note;
      valid_nxt = valid;

      case (state)
         S_IDLE: begin
            if (iSTART && !iSTOP) begin
               track_nxt = iTRACK;
               last_nxt  = iLAST;
               idx_nxt   = '0;
               addr_nxt  = {iTRACK, 4'd0};
               state_nxt = S_FETCH;
            end
         end
         S_FETCH: state_nxt = S_LOAD;
         S_LOAD: begin
            note_nxt  = iRD_DATA[5:0];
            len_nxt   = iRD_DATA[8:6];
            tempo_nxt = iTEMPO;
            tick_nxt  = '0;
            unit_nxt  = '0;
            dur_nxt   = '0;
            valid_nxt = (iRD_DATA[3:0] != 4'hF);
            state_nxt = S_PLAY;
         end
         S_PLAY: begin
            if (tick == TICK_LAST) begin
               tick_nxt = '0;
               if (unit == (2'd3 - tempo)) begin
                  unit_nxt = '0;
                  if (dur == len) begin
                     dur_nxt   = '0;
                     valid_nxt = 1'b0;
                     state_nxt = S_GAP;
                  end else begin
                     dur_nxt = dur + 3'd1;
                  end
               end else begin
                  unit_nxt = unit + 2'd1;
               end
            end else begin
               tick_nxt = tick + TW'(1);
            end
         end
         S_GAP: begin
            if (tick == TICK_LAST) begin
               tick_nxt = '0;
               if (idx != last) begin
                  idx_nxt   = idx + 4'd1;
                  addr_nxt  = {track, idx + 4'd1};
                  state_nxt = S_FETCH;
               end else if (iLOOP) begin
                  idx_nxt   = '0;
                  addr_nxt  = {track, 4'd0};
                  state_nxt = S_FETCH;
               end else begin
                  state_nxt = S_END;
               end
            end else begin
               tick_nxt = tick + TW'(1);
            end
         end
         S_END:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase

      // Abort and restart override the per-state behaviour; stop has priority.
      if (state != S_IDLE) begin
         if (iSTOP) begin
            state_nxt = S_IDLE;
            valid_nxt = 1'b0;
            note_nxt  = '0;
            idx_nxt   = '0;
            tick_nxt  = '0;
            unit_nxt  = '0;
            dur_nxt   = '0;
         end else if (iSTART) begin
            track_nxt = iTRACK;
            last_nxt  = iLAST;
            idx_nxt   = '0;
            addr_nxt  = {iTRACK, 4'd0};
            valid_nxt = 1'b0;
            tick_nxt  = '0;
            unit_nxt  = '0;
            dur_nxt   = '0;
            state_nxt = S_FETCH;
         end
      end

      busy_nxt = (state_nxt != S_IDLE);
      done_nxt = (state_nxt == S_END);
   end

   assign oRD_ADDR    = addr;
   assign oNOTE       = note;
   assign oNOTE_VALID = valid;
   assign oNOTE_IDX   = idx;
   assign oBUSY       = busy;
   assign oDONE       = done;
   assign oSTATE      = state;

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed bench with a per-cycle expected-trace model.
// The model expands a playback request into the list of per-cycle output frames
// that the track must produce; one compare process pops a frame every cycle.
module tb_note_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, stop, loop_en;
   logic [2:0] track;
   logic [3:0] last_i;
   logic [1:0] tempo;
   logic [6:0] rd_addr;
   logic [8:0] rd_data;
   logic [5:0] note;
   logic       note_valid;
   logic [3:0] note_idx;
   logic       busy, done;
   logic [2:0] state;

   note_sequencer #(.TICK_DIV(4)) dut (
      .iCLK(clk), .iRST_N(rst_n), .iSTART(start), .iSTOP(stop), .iLOOP(loop_en),
      .iTRACK(track), .iLAST(last_i), .iTEMPO(tempo), .oRD_ADDR(rd_addr),
      .iRD_DATA(rd_data), .oNOTE(note), .oNOTE_VALID(note_valid),
      .oNOTE_IDX(note_idx), .oBUSY(busy), .oDONE(done), .oSTATE(state)
   );

   always #5 clk = ~clk;

   // Note store: synchronous RAM, data valid one cycle after the address.
   logic [8:0] mem [0:127];
   always @(posedge clk) rd_data <= mem[rd_addr];

   typedef struct packed {
      logic [2:0] st;
      logic [6:0] addr;
      logic [5:0] note;
      logic       valid;
      logic [3:0] idx;
      logic       busy;
      logic       done;
   } frame_t;

   frame_t q[$];
   frame_t last_f;
   int tests = 0, fails = 0;
   int cnt_valid = 0, cnt_done = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Expand a playback of notes 0..lst of track tr, repeated reps times, ending in END.
   task automatic gen(input logic [2:0] tr, input logic [3:0] lst, input logic [1:0] t,
                      input int reps);
      frame_t f;
      logic [5:0] cn;
      logic [8:0] e;
      int n;
      q.delete();
      cn = last_f.note;
      for (int r = 0; r < reps; r++) begin
         for (int i = 0; i <= int'(lst); i++) begin
            f.addr = {tr, 4'(i)};
            f.idx = 4'(i);
            f.busy = 1'b1;
            f.done = 1'b0;
            f.valid = 1'b0;
            f.note = cn;
            f.st = 3'd1; q.push_back(f);
            f.st = 3'd2; q.push_back(f);
            e = mem[{tr, 4'(i)}];
            cn = e[5:0];
            n = (int'(e[8:6]) + 1) * (4 - int'(t)) * 4;
            f.note = cn;
            f.st = 3'd3;
            f.valid = (e[3:0] != 4'hF);
            for (int k = 0; k < n; k++) q.push_back(f);
            f.st = 3'd4;
            f.valid = 1'b0;
            for (int k = 0; k < 4; k++) q.push_back(f);
         end
      end
      f.st = 3'd5;
      f.done = 1'b1;
      q.push_back(f);
   endtask

   function automatic int count_st(input logic [2:0] s);
      int c = 0;
      foreach (q[i]) if (q[i].st == s) c++;
      return c;
   endfunction

   function automatic int play_run(input int k);
      int run = 0, cnt = 0;
      foreach (q[i]) begin
         if (q[i].st == 3'd3) run++;
         else if (run > 0) begin
            if (cnt == k) return run;
            cnt++;
            run = 0;
         end
      end
      return -1;
   endfunction

   function automatic int fetch_addr(input int k);
      int cnt = 0;
      foreach (q[i]) if (q[i].st == 3'd1) begin
         if (cnt == k) return int'(q[i].addr);
         cnt++;
      end
      return -1;
   endfunction

   // Compare DUT outputs against the model frame for every cycle.
   always begin
      frame_t exp, act;
      @(posedge clk);
      #1;
      if (q.size() > 0) exp = q.pop_front();
      else begin
         exp = last_f;
         exp.st = 3'd0; exp.valid = 1'b0; exp.busy = 1'b0; exp.done = 1'b0;
      end
      last_f = exp;
      act = '{state, rd_addr, note, note_valid, note_idx, busy, done};
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL cycle t=%0t got st=%0d addr=%h note=%h v=%b idx=%0d busy=%b done=%b expected st=%0d addr=%h note=%h v=%b idx=%0d busy=%b done=%b",
                  $time, act.st, act.addr, act.note, act.valid, act.idx, act.busy, act.done,
                  exp.st, exp.addr, exp.note, exp.valid, exp.idx, exp.busy, exp.done);
      end
      cnt_valid += int'(note_valid);
      cnt_done  += int'(done);
   end

   task automatic start_play(input logic [2:0] tr, input logic [3:0] lst, input logic [1:0] t,
                             input int reps);
      @(negedge clk);
      track = tr; last_i = lst; tempo = t; start = 1'b1;
      gen(tr, lst, t, reps);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic stop_now();
      @(negedge clk);
      stop = 1'b1;
      q.delete();
      last_f.note = '0;
      last_f.idx = '0;
      @(negedge clk);
      stop = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int c = 0;
      while (q.size() > 0 && c < 3000) begin
         @(negedge clk);
         c++;
      end
      if (q.size() > 0) chk({name, "_timeout"}, q.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_for(input logic [2:0] s, input logic [3:0] i, input string name);
      int c = 0;
      while (!(last_f.st == s && last_f.idx == i) && c < 3000) begin
         @(negedge clk);
         c++;
      end
      chk({name, "_reached"}, int'(c < 3000), 1);
   endtask

   initial begin
      foreach (mem[i]) mem[i] = '0;
      mem[7'h00] = 9'b001_01_0010;
      mem[7'h50] = 9'b000_10_0101;
      mem[7'h51] = 9'b010_11_1001;
      mem[7'h52] = 9'b001_00_0111;
      mem[7'h20] = 9'b001_00_1111;
      mem[7'h21] = 9'b000_01_0011;
      mem[7'h30] = 9'b001_10_0001;
      mem[7'h31] = 9'b001_01_0100;
      last_f = '0;
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
      track = '0; last_i = '0; tempo = '0;
      #1;
      chk("reset_state", int'(state), 0);
      chk("reset_outs", int'({rd_addr, note, note_valid, note_idx, busy, done}), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single note: 8 sounding cycles, 4 gap cycles, one done pulse.
      cnt_valid = 0; cnt_done = 0;
      start_play(3'd0, 4'd0, 2'd3, 1);
      wait_idle("single");
      chk("single_valid_cycles", cnt_valid, 8);
      chk("single_done", cnt_done, 1);
      chk("single_note", int'(note), 'h12);

      // Three notes on track 5 at tempo 1; track/last changes mid-play are ignored.
      @(negedge clk);
      track = 3'd5; last_i = 4'd2; tempo = 2'd1; start = 1'b1;
      gen(3'd5, 4'd2, 2'd1, 1);
      chk("three_play0", play_run(0), 12);
      chk("three_play1", play_run(1), 36);
      chk("three_play2", play_run(2), 24);
      chk("three_addr0", fetch_addr(0), 'h50);
      chk("three_addr1", fetch_addr(1), 'h51);
      chk("three_addr2", fetch_addr(2), 'h52);
      chk("three_gaps", count_st(3'd4), 12);
      cnt_done = 0;
      @(negedge clk);
      start = 1'b0;
      track = 3'd0; last_i = 4'd0;
      wait_idle("three");
      chk("three_done", cnt_done, 1);

      // Rest then a short note: only the second note sounds (4 cycles).
      cnt_valid = 0; cnt_done = 0;
      start_play(3'd2, 4'd1, 2'd3, 1);
      wait_idle("rest");
      chk("rest_valid_cycles", cnt_valid, 4);
      chk("rest_idx", int'(note_idx), 1);

      // Loop over two notes, then drop loop during the final note.
      cnt_done = 0;
      loop_en = 1'b1;
      start_play(3'd3, 4'd1, 2'd3, 3);
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (q.size() <= 10) break;
      end
      loop_en = 1'b0;
      wait_idle("loop");
      chk("loop_done", cnt_done, 1);

      // Stop during a gap: idle next cycle, no done.
      cnt_done = 0;
      start_play(3'd5, 4'd2, 2'd3, 1);
      wait_for(3'd4, 4'd0, "stop_gap");
      stop_now();
      wait_idle("stop");
      chk("stop_done", cnt_done, 0);

      // Start and stop together from idle: stays idle.
      @(negedge clk);
      start = 1'b1; stop = 1'b1;
      @(posedge clk);
      #2;
      chk("startstop_state", int'(state), 0);
      chk("startstop_busy", int'(busy), 0);
      @(negedge clk);
      start = 1'b0; stop = 1'b0;

      // Restart during the second note's play.
      cnt_done = 0;
      start_play(3'd5, 4'd2, 2'd1, 1);
      wait_for(3'd3, 4'd1, "restart");
      repeat (5) @(negedge clk);
      start = 1'b1;
      gen(3'd5, 4'd2, 2'd1, 1);
      @(posedge clk);
      #2;
      chk("restart_state", int'(state), 1);
      chk("restart_addr", int'(rd_addr), 'h50);
      @(negedge clk);
      start = 1'b0;
      wait_idle("restart");
      chk("restart_done", cnt_done, 1);

      // Asynchronous reset mid-play.
      cnt_done = 0;
      start_play(3'd5, 4'd2, 2'd1, 1);
      wait_for(3'd3, 4'd0, "areset");
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      q.delete();
      last_f = '0;
      #1;
      chk("areset_state", int'(state), 0);
      chk("areset_outs", int'({rd_addr, note, note_valid, note_idx, busy, done}), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("areset_done", cnt_done, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Playback controller for one stored track. It walks the note-store entries of the selected track in order and times each note from its length field and the tempo setting. It presents the current {octave, pitch} to the frequency lookup/tone generator and reports end of track. It sits between the note store (synchronous RAM, 8 tracks × 16 entries × 9 bits) and the noteLookup/toneGen datapath, and replaces free-running note advance with an explicit FSM.

## Interface
- TICK_DIV, 3125000: iCLK cycles per base tick (62.5 ms at 50 MHz); bench uses 4.
- iCLK  in  1  system clock (CLOCK_50 domain).
- iRST_N  in  1  asynchronous active-low reset.
- iSTART  in  1  single-cycle pulse: start or restart playback at note 0.
- iSTOP  in  1  single-cycle pulse: abort playback.
- iLOOP  in  1  level: wrap to note 0 after the last note instead of finishing.
- iTRACK  in  3  track select, sampled on the iSTART edge.
- iLAST  in  4  index of the last valid note of the track, sampled on the iSTART edge.
- iTEMPO  in  2  tempo select, sampled on every entry to PLAY; 3 is fastest.
- oRD_ADDR  out  7  note-store address {track, index}.
- iRD_DATA  in  9  note entry: [8:6] length, [5:4] octave, [3:0] pitch. Valid one cycle after oRD_ADDR.
- oNOTE  out  6  {octave, pitch} of the note being played.
- oNOTE_VALID  out  1  high while a non-rest note sounds.
- oNOTE_IDX  out  4  index of the current note, for the LEDR display.
- oBUSY  out  1  high in every state except IDLE.
- oDONE  out  1  one-cycle pulse when a non-looping track finishes.
- oSTATE  out  3  FSM state for the LEDG debug display: IDLE=0, FETCH=1, LOAD=2, PLAY=3, GAP=4, END=5.

## Operation
- Reset values: state IDLE. oRD_ADDR, oNOTE, oNOTE_IDX and all counters are 0. oNOTE_VALID, oBUSY and oDONE are 0.
- IDLE: on iSTART, latch track and last index, set index=0 and go to FETCH.
- FETCH: oRD_ADDR = {track, index}. Next state is LOAD.
- LOAD: the RAM returns data during this cycle. On exit, register oNOTE = iRD_DATA[5:0], length field L = iRD_DATA[8:6] and tempo T = iTEMPO, clear all timing counters, and go to PLAY.
- PLAY lasts exactly (L+1) × (4−T) × TICK_DIV cycles.
  - Timing uses three counters: a tick counter 0..TICK_DIV−1, a unit counter 0..3−T, and a duration counter 0..L.
  - oNOTE_VALID=1 unless pitch==4'hF (rest). A rest keeps full duration with oNOTE_VALID=0.
  - After the last cycle, go to GAP.
- GAP: articulation silence of exactly TICK_DIV cycles with oNOTE_VALID=0; oNOTE holds its value. On exit:
  - index != last: index+1, go to FETCH.
  - index == last and iLOOP=1: index=0, go to FETCH.
  - index == last and iLOOP=0: go to END.
- END: oDONE=1 for this single cycle, then go to IDLE.
- oNOTE_IDX follows index. oBUSY = (state != IDLE).
- Counter widths: tick counter is ceil(log2(TICK_DIV)) bits, unit counter 2 bits, duration counter 3 bits. No counter may overflow at L=7, T=0.

Boundary conditions:
- iSTOP in any non-IDLE state: next state IDLE, oNOTE_VALID=0, oNOTE=0, index=0, no oDONE.
- iSTART and iSTOP in the same cycle: iSTOP wins.
- iSTART while busy (not stopping): restart. Re-latch track and last index, index=0, go to FETCH; the current note is cut with no GAP.
- iLAST=0: a single-note track (one PLAY, one GAP).
- iTRACK, iLAST and iLOOP changes mid-play: track and last index take effect only at the next iSTART. iLOOP is evaluated live at the end of GAP.
- Asynchronous reset mid-operation forces the reset values immediately. No oDONE is issued.

## Timing
- iSTART sampled at edge E0 → FETCH after E0 → LOAD after E0+1 → oNOTE and oNOTE_VALID update at E0+2.
- Note-to-note period: PLAY + TICK_DIV (GAP) + 2 cycles (FETCH, LOAD).
- oDONE is asserted in the cycle after the final GAP. oBUSY falls one cycle later.
- iTEMPO changes affect only the next note.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
All scenarios use TICK_DIV=4.
- Reset: hold iRST_N=0 mid-PLAY → all outputs 0 and oSTATE=0 asynchronously, before the next edge.
- Single note: iLAST=0, entry 9'b001_01_0010, T=3, iLOOP=0.
  - oNOTE=6'h12 and oNOTE_VALID high for exactly 8 cycles.
  - Then 4 GAP cycles, then oDONE pulses for 1 cycle.
- Three notes on track 5 with lengths 0/2/1 at T=1:
  - oRD_ADDR reads 0x50, 0x51, 0x52.
  - PLAY lengths are 12/36/24 cycles, each followed by a 4-cycle GAP.
  - Exactly one oDONE.
- Rest entry (pitch 4'hF, L=1, T=3): oNOTE_VALID stays 0 for 8 PLAY cycles and the index still advances.
- Loop with iLAST=1 and iLOOP=1: addresses run 0,1,0,1,… with no oDONE. Drop iLOOP during note 1 → oDONE after that note's GAP.
- iSTOP during GAP: next cycle IDLE, no oDONE. iSTART+iSTOP in the same cycle from IDLE → stays IDLE. iSTART mid-PLAY of note 2 → FETCH at address {track, 0}.
